// File: rtl/div_ctrl_if.sv
// Request/response handshake bundle between the execute pipeline and div_ctrl.
//   req_*  : pipeline -> controller divide request (valid/ready)
//   resp_* : controller -> pipeline result (valid/ready)
// master = pipeline side, slave = controller side.
interface div_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_rd;

  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_rd;

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd
  );

endinterface

// File: rtl/div_ctrl.sv
// Issue/sequencing controller for the iterative M-extension divider.
// Accepts DIV/DIVU/REM/REMU, resolves divide-by-zero and signed overflow
// locally, otherwise starts the divider and returns the selected result.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : req_valid/ready/op/a/b/rd, resp_valid/ready/data/rd
//   flush           : kill the pending or in-flight operation
//   busy            : controller not idle
//   div_start       : one-cycle start pulse to the divider
//   div_is_signed   : signed operation
//   div_is_rem      : remainder selected
//   div_dividend    : registered operand a
//   div_divisor     : registered operand b
//   div_result      : divider quotient
//   div_remainder   : divider remainder
//   div_done        : divider completion pulse
//   div_busy        : divider busy
//
// Optional feature: define DIV_CACHE_EN to keep the last divider result and
// answer a repeat of the same operands/signedness without starting the divider.
module div_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  div_ctrl_if.slave       bus,
  input  logic            flush,
  output logic            busy,
  output logic            div_start,
  output logic            div_is_signed,
  output logic            div_is_rem,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic [XLEN-1:0] div_result,
  input  logic [XLEN-1:0] div_remainder,
  input  logic            div_done,
  input  logic            div_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [XLEN-1:0]  resp_data_q;
  logic [TAG_W-1:0] resp_rd_q;

  logic             accept;
  logic             op_signed;
  logic             op_rem;
  logic             b_zero;
  logic             overflow;
  logic             special;
  logic [XLEN-1:0]  special_data;
  logic             hit;
  logic [XLEN-1:0]  hit_data;

  // Handshake and status outputs, all forced low while reset is high
  assign bus.req_ready  = (state == S_IDLE) && !reset && !flush;
  assign bus.resp_valid = (state == S_RESP) && !reset;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_rd    = resp_rd_q;
  assign busy           = (state != S_IDLE) && !reset;

  assign accept    = bus.req_valid && bus.req_ready;
  assign op_signed = ~bus.req_op[0];
  assign op_rem    = bus.req_op[1];

  // RISC-V divide-by-zero and INT_MIN / -1 results, resolved without the divider
  assign b_zero       = (bus.req_b == XLEN'(0));
  assign overflow     = op_signed && (bus.req_a == INT_MIN) && (bus.req_b == ALL_ONES);
  assign special      = b_zero || overflow;
  assign special_data = b_zero ? (op_rem ? bus.req_a : ALL_ONES)
                               : (op_rem ? XLEN'(0) : bus.req_a);

`ifdef DIV_CACHE_EN
  logic            c_valid;
  logic            c_signed;
  logic [XLEN-1:0] c_a;
  logic [XLEN-1:0] c_b;
  logic [XLEN-1:0] c_q;
  logic [XLEN-1:0] c_r;

  // Quotient and remainder are both kept, so DIV and REM forms share an entry
  assign hit      = c_valid && (bus.req_a == c_a) && (bus.req_b == c_b) &&
                    (op_signed == c_signed);
  assign hit_data = op_rem ? c_r : c_q;

  // Any completed divide refreshes the entry, including one drained after flush
  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid  <= 1'b0;
      c_signed <= 1'b0;
      c_a      <= '0;
      c_b      <= '0;
      c_q      <= '0;
      c_r      <= '0;
    end else if (div_done && ((state == S_WAIT) || (state == S_DRAIN))) begin
      c_valid  <= 1'b1;
      c_signed <= div_is_signed;
      c_a      <= div_dividend;
      c_b      <= div_divisor;
      c_q      <= div_result;
      c_r      <= div_remainder;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and start pulse; flush outranks div_done
  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (special || hit) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (!div_busy) begin
          div_start = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_nxt = div_done ? S_IDLE : S_DRAIN;
        end else if (div_done) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (flush || bus.resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (div_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) begin
      state_nxt = S_IDLE;
      div_start = 1'b0;
    end
  end

  // Operand/tag capture at accept and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_is_signed <= 1'b0;
      div_is_rem    <= 1'b0;
      resp_rd_q     <= '0;
      resp_data_q   <= '0;
    end else begin
      if (accept) begin
        div_dividend  <= bus.req_a;
        div_divisor   <= bus.req_b;
        div_is_signed <= op_signed;
        div_is_rem    <= op_rem;
        resp_rd_q     <= bus.req_rd;
        if (special) begin
          resp_data_q <= special_data;
        end else if (hit) begin
          resp_data_q <= hit_data;
        end
      end
      if ((state == S_WAIT) && div_done && !flush) begin
        resp_data_q <= div_is_rem ? div_remainder : div_result;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: a behavioural divider responder, a stimulus
// process that pushes expected results, and a monitor that compares every
// presented response against the queue head.
module tb_div_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

`ifdef DIV_CACHE_EN
  localparam int EXP_CACHE_STARTS = 1;
`else
  localparam int EXP_CACHE_STARTS = 2;
`endif

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    bit          fast;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        busy;
  logic        div_start;
  logic        div_is_signed;
  logic        div_is_rem;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_result;
  logic [31:0] div_remainder;
  logic        div_done;
  logic        div_busy;
  logic        dv_busy;
  logic        extra_busy;
  logic        eb_rnd;
  bit          eb_rand;
  logic        rr_rnd;
  logic        rr_val;
  bit          rr_rand;
  int          dv_lat;
  int          dv_cnt;
  int          tot_starts = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb_q[$];

`ifdef DIV_CACHE_EN
  bit          m_cv;
  bit          m_cs;
  logic [31:0] m_ca;
  logic [31:0] m_cb;
`endif

  always #5 clk = ~clk;

  div_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  assign div_busy       = dv_busy | extra_busy;
  assign extra_busy     = eb_rand ? eb_rnd : 1'b0;
  assign bus.resp_ready = rr_rand ? rr_rnd : rr_val;

  div_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .flush         (flush),
    .busy          (busy),
    .div_start     (div_start),
    .div_is_signed (div_is_signed),
    .div_is_rem    (div_is_rem),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_result    (div_result),
    .div_remainder (div_remainder),
    .div_done      (div_done),
    .div_busy      (div_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M-extension divide semantics
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    bit sgn = !op[0];
    bit rem = op[1];
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Random resp_ready / divider back-pressure sources
  initial begin
    rr_rnd = 1'b1;
    eb_rnd = 1'b0;
    forever begin
      @(negedge clk);
      rr_rnd = ($urandom_range(0, 1) == 1);
      eb_rnd = ($urandom_range(0, 3) == 0);
    end
  end

  // Behavioural iterative divider: done arrives dv_lat cycles after a start
  initial begin
    dv_busy       = 1'b0;
    div_done      = 1'b0;
    div_result    = '0;
    div_remainder = '0;
    dv_cnt        = 0;
    forever begin
      @(negedge clk);
      #1;
      div_done = 1'b0;
      if (reset) begin
        dv_busy = 1'b0;
        dv_cnt  = 0;
      end else begin
        if (dv_cnt > 0) begin
          dv_cnt--;
          if (dv_cnt == 0) begin
            div_done = 1'b1;
            dv_busy  = 1'b0;
          end else begin
            dv_busy = 1'b1;
          end
        end
        if (div_start) begin
          div_result    = ref_div({1'b0, ~div_is_signed}, div_dividend, div_divisor);
          div_remainder = ref_div({1'b1, ~div_is_signed}, div_dividend, div_divisor);
          dv_cnt        = (dv_lat > 0) ? dv_lat : $urandom_range(1, 6);
        end
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head
  initial begin
    int   cyc;
    int   starts;
    bit   seen;
    exp_t e;
    cyc    = 0;
    starts = 0;
    seen   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        cyc    = 0;
        starts = 0;
        continue;
      end
      cyc++;
      if (div_start) begin
        starts++;
        tot_starts++;
      end
      if (bus.req_valid && bus.req_ready) begin
        cyc    = 0;
        starts = 0;
        seen   = 1'b0;
      end
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
        end else begin
          e = sb_q[0];
          if (!seen) begin
            seen = 1'b1;
            if (e.fast) check("fast_latency", 32'(cyc), 32'd1);
            check("start_count", 32'(starts), e.fast ? 32'd0 : 32'd1);
          end
          check("resp_data", bus.resp_data, e.data);
          check("resp_rd", 32'(bus.resp_rd), 32'(e.rd));
          if (bus.resp_ready || flush) void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit want);
    bit   sgn = !op[0];
    bit   special;
    bit   hit = 1'b0;
    bit   ok = 1'b0;
    exp_t e;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_rd    = rd;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("req_accept", 32'(ok), 32'd1);
    if (ok) begin
      special = (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_CACHE_EN
      hit = !special && m_cv && a == m_ca && b == m_cb && sgn == m_cs;
      if (!special && !hit) begin
        m_cv = 1'b1;
        m_ca = a;
        m_cb = b;
        m_cs = sgn;
      end
`endif
      e.data = ref_div(op, a, b);
      e.rd   = rd;
      e.fast = special || hit;
      if (want) sb_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
`ifdef DIV_CACHE_EN
    m_cv = 1'b0;
`endif
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (div_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("start_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stimulus
  initial begin
    int          s0;
    bit          ok;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    logic [4:0]  rrd;
    reset         = 1'b1;
    flush         = 1'b0;
    rr_rand       = 1'b0;
    rr_val        = 1'b1;
    eb_rand       = 1'b0;
    dv_lat        = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_a     = 32'h1234_5678;
    bus.req_b     = 32'h0;
    bus.req_rd    = 5'd1;
    ra            = '0;
    rb            = '0;
`ifdef DIV_CACHE_EN
    m_cv = 1'b0;
    m_cs = 1'b0;
    m_ca = '0;
    m_cb = '0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_div_start", 32'(div_start), 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    reset         = 1'b0;

    // Signed divide through the divider
    do_req(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1);
    wait_idle();

    // Divide by zero and signed overflow resolved locally
    s0 = tot_starts;
    do_req(2'b11, 32'd7, 32'd0, 5'd4, 1'b1);
    do_req(2'b01, 32'd7, 32'd0, 5'd5, 1'b1);
    do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1);
    do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1);
    wait_idle();
    check("special_no_start", 32'(tot_starts - s0), 32'd0);

    // Response held under back-pressure
    rr_val = 1'b0;
    do_req(2'b11, 32'd55, 32'd0, 5'd8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    rr_val = 1'b1;
    @(negedge clk);
    #1;
    check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    check("post_hs_resp_valid", 32'(bus.resp_valid), 32'd0);

    // Flush while a response is pending
    rr_val = 1'b0;
    do_req(2'b01, 32'd9, 32'd0, 5'd9, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("flush_resp_ready", 32'(bus.req_ready), 32'd1);
    rr_val = 1'b1;
    wait_idle();

    // Flush during WAIT: drain until div_done, then idle
    dv_lat = 6;
    do_req(2'b01, 32'd100, 32'd7, 5'd10, 1'b0);
    wait_start(ok);
    if (ok) begin
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      for (int i = 2; i <= 6; i++) begin
        #1;
        check("drain_req_ready", 32'(bus.req_ready), 32'd0);
        check("drain_busy", 32'(busy), 32'd1);
        @(negedge clk);
      end
      #1;
      check("drain_done_req_ready", 32'(bus.req_ready), 32'd1);
    end
    wait_idle();

    // Flush coincident with div_done: no response
    do_req(2'b00, 32'd1000, 32'd3, 5'd11, 1'b0);
    wait_start(ok);
    if (ok) begin
      repeat (6) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_done_req_ready", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
        check("flush_done_no_resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        #1;
      end
    end
    dv_lat = 0;
    wait_idle();

    // DIVU then REMU on the same operands
    do_reset();
    s0 = tot_starts;
    do_req(2'b01, 32'd100, 32'd7, 5'd12, 1'b1);
    do_req(2'b11, 32'd100, 32'd7, 5'd13, 1'b1);
    wait_idle();
    check("cache_starts", 32'(tot_starts - s0), 32'(EXP_CACHE_STARTS));

    // Randomized traffic with back-pressure on both sides
    do_reset();
    rr_rand = 1'b1;
    eb_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (n == 0 || $urandom_range(0, 3) != 0) begin
        ra = pick();
        rb = pick();
      end
      rop = 2'($urandom_range(0, 3));
      rrd = 5'($urandom);
      do_req(rop, ra, rb, rrd, 1'b1);
    end
    wait_idle();
    rr_rand = 1'b0;
    eb_rand = 1'b0;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
